inpmem_ctrl: RTL and testbench

Sequencer and arbiter in front of the input activation memory (`inpmem`, 32 KiB, 15-bit byte address, 8-bit data, 1-cycle read latency). It shares the memory's single port between a host write channel, which loads activations, and a strided read streamer, which feeds the systolic array input edge through a 2-entry output buffer with valid/ready backpressure. It owns all `CEN`/`WEN`/`A`/`D` traffic to the memory.

---
 rtl/systola_pkg.sv | 35 +++
 rtl/skid_fifo2.sv | 81 ++++++++
 rtl/inpmem_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_inpmem_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systola_pkg.sv
// ---------------------------------------------------------------------------
// systola_pkg
// Shared definitions for the systolic-array front end: memory geometry, the
// stream sequencer state encoding and the single-port grant encoding.
// ---------------------------------------------------------------------------
package systola_pkg;

    // Input activation memory geometry (32 KiB, byte addressed)
    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 16;

    // Stream sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    // Owner of the memory port in the current cycle
    localparam logic [1:0] GNT_NONE   = 2'd0;
    localparam logic [1:0] GNT_HOST   = 2'd1;
    localparam logic [1:0] GNT_STREAM = 2'd2;

    // Elements owned by the read path: buffered entries plus the read still
    // in flight, minus the one leaving the buffer this cycle.
    function automatic logic [2:0] stream_occupancy(
        input logic [1:0] buf_count,
        input logic       in_flight,
        input logic       popping
    );
        return {1'b0, buf_count} + {2'b00, in_flight} - {2'b00, popping};
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// ---------------------------------------------------------------------------
// skid_fifo2
// Two-entry valid/ready buffer. The head entry drives out_data directly from
// a register, so data stays stable while the consumer stalls.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid, in_data   write side (the producer guarantees it never pushes
//                       into a full buffer; a push while full is dropped)
//   out_valid, out_ready, out_data  read side handshake
//   count               number of occupied entries (0..2)
// ---------------------------------------------------------------------------
module skid_fifo2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] tail_r;
    logic [1:0]        count_r;
    logic              pop_s;
    logic              push_s;

    // Handshake decode for this cycle
    always_comb begin
        pop_s  = (count_r != 2'd0) && out_ready;
        push_s = in_valid;
    end

    // Entry storage and occupancy update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {DATA_W{1'b0}};
            tail_r  <= {DATA_W{1'b0}};
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r  <= in_data;
                        count_r <= 2'd1;
                    end else if (count_r == 2'd1) begin
                        tail_r  <= in_data;
                        count_r <= 2'd2;
                    end else begin
                        count_r <= count_r;
                    end
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new element lands behind
                    // whatever remains after the pop.
                    if (count_r == 2'd1) begin
                        head_r <= in_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= in_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign out_valid = (count_r != 2'd0);
    assign out_data  = head_r;
    assign count     = count_r;

endmodule

// File: rtl/inpmem_ctrl.sv
// ---------------------------------------------------------------------------
// inpmem_ctrl
// Sequencer and arbiter owning the single port of the input activation
// memory. A host write channel and a strided read streamer share the port;
// streamed elements leave through a 2-entry valid/ready buffer.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   host_wvalid/wready/waddr/wdata    host write channel (wready is
//                                     combinational: granted this cycle)
//   start, base, len, stride          stream launch, sampled with start
//   busy, done                        stream status, done is a 1-cycle pulse
//   out_valid, out_ready, out_data    streamed elements to the array edge
//   mem_CEN, mem_WEN, mem_A, mem_D    memory controls (active-low enables)
//   mem_Q                             memory read data, 1-cycle latency
// ---------------------------------------------------------------------------
module inpmem_ctrl #(
    parameter int ADDR_W = systola_pkg::ADDR_W,
    parameter int DATA_W = systola_pkg::DATA_W,
    parameter int LEN_W  = systola_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_wvalid,
    output logic              host_wready,
    input  logic [ADDR_W-1:0] host_waddr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] stride,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              mem_CEN,
    output logic              mem_WEN,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_D,
    input  logic [DATA_W-1:0] mem_Q
);

    import systola_pkg::*;

    state_e            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] stride_r;
    logic [LEN_W-1:0]  remain_r;
    logic [ADDR_W-1:0] hold_a_r;
    logic [DATA_W-1:0] hold_d_r;
    logic              inflight_r;
    logic              last_grant_host_r;
    logic              busy_r;
    logic              done_r;

    logic [1:0]        fifo_count_s;
    logic              fifo_valid_s;
    logic              pop_s;
    logic [2:0]        occ_s;
    logic              sreq_s;
    logic [1:0]        gnt_s;
    logic              drain_done_s;

    // Consumer handshake and read-path occupancy. Counting the element that
    // leaves this cycle keeps a full-rate stream at one issue per cycle
    // while still bounding buffered plus in-flight elements at two.
    always_comb begin
        pop_s = fifo_valid_s && out_ready;
        occ_s = stream_occupancy(fifo_count_s, inflight_r, pop_s);
    end

    // Stream read request: only while issuing and only if the buffer has room
    always_comb begin
        if ((state_r == ST_STREAM) && (occ_s < 3'd2)) begin
            sreq_s = 1'b1;
        end else begin
            sreq_s = 1'b0;
        end
    end

    // Port arbitration: on contention the side that did not win last time wins
    always_comb begin
        if (host_wvalid && !(sreq_s && last_grant_host_r)) begin
            gnt_s = GNT_HOST;
        end else if (sreq_s) begin
            gnt_s = GNT_STREAM;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Memory port drive; address and data hold their last value when idle
    always_comb begin
        host_wready = 1'b0;
        mem_CEN     = 1'b1;
        mem_WEN     = 1'b1;
        mem_A       = hold_a_r;
        mem_D       = hold_d_r;
        case (gnt_s)
            GNT_HOST: begin
                host_wready = 1'b1;
                mem_CEN     = 1'b0;
                mem_WEN     = 1'b0;
                mem_A       = host_waddr;
                mem_D       = host_wdata;
            end
            GNT_STREAM: begin
                mem_CEN = 1'b0;
                mem_A   = addr_r;
            end
            default: begin
                mem_CEN = 1'b1;
            end
        endcase
    end

    // The stream is finished once the last buffered element is handed over
    // and nothing is still in flight (immediately true for a zero length)
    always_comb begin
        if (!inflight_r && ((fifo_count_s == 2'd0) ||
                            ((fifo_count_s == 2'd1) && pop_s))) begin
            drain_done_s = 1'b1;
        end else begin
            drain_done_s = 1'b0;
        end
    end

    // Grant history and memory bus hold registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r        <= 1'b0;
            last_grant_host_r <= 1'b0;
            hold_a_r          <= {ADDR_W{1'b0}};
            hold_d_r          <= {DATA_W{1'b0}};
        end else begin
            inflight_r <= (gnt_s == GNT_STREAM);
            case (gnt_s)
                GNT_HOST: begin
                    last_grant_host_r <= 1'b1;
                    hold_a_r          <= host_waddr;
                    hold_d_r          <= host_wdata;
                end
                GNT_STREAM: begin
                    last_grant_host_r <= 1'b0;
                    hold_a_r          <= addr_r;
                end
                default: begin
                    last_grant_host_r <= last_grant_host_r;
                end
            endcase
        end
    end

    // Stream sequencer: launch, address generation, drain and completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            addr_r   <= {ADDR_W{1'b0}};
            stride_r <= {ADDR_W{1'b0}};
            remain_r <= {LEN_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (done_r) begin
                        // done cycle: busy drops after it, start still ignored
                        busy_r <= 1'b0;
                    end else if (start && !busy_r) begin
                        addr_r   <= base;
                        stride_r <= stride;
                        remain_r <= len;
                        busy_r   <= 1'b1;
                        if (len == {LEN_W{1'b0}}) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_STREAM;
                        end
                    end else begin
                        busy_r <= busy_r;
                    end
                end
                ST_STREAM: begin
                    if (gnt_s == GNT_STREAM) begin
                        // Address wraps silently modulo the memory size
                        addr_r   <= addr_r + stride_r;
                        remain_r <= remain_r - {{(LEN_W-1){1'b0}}, 1'b1};
                        if (remain_r == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_STREAM;
                        end
                    end else begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output buffer: read data is captured the cycle after its issue
    skid_fifo2 #(
        .DATA_W (DATA_W)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inflight_r),
        .in_data   (mem_Q),
        .out_valid (fifo_valid_s),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (fifo_count_s)
    );

    assign out_valid = fifo_valid_s;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_inpmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inpmem_ctrl
// Self-checking bench: a behavioural memory, a table of directed streams,
// a reset-mid-stream sequence and randomized streams, all compared every
// cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_inpmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_wvalid;
    logic        host_wready;
    logic [14:0] host_waddr;
    logic [7:0]  host_wdata;
    logic        start;
    logic [14:0] base;
    logic [15:0] len;
    logic [14:0] stride;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        mem_CEN;
    logic        mem_WEN;
    logic [14:0] mem_A;
    logic [7:0]  mem_D;
    logic [7:0]  mem_Q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inpmem_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_wvalid (host_wvalid),
        .host_wready (host_wready),
        .host_waddr  (host_waddr),
        .host_wdata  (host_wdata),
        .start       (start),
        .base        (base),
        .len         (len),
        .stride      (stride),
        .busy        (busy),
        .done        (done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .mem_CEN     (mem_CEN),
        .mem_WEN     (mem_WEN),
        .mem_A       (mem_A),
        .mem_D       (mem_D),
        .mem_Q       (mem_Q)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'((i ^ (i >> 8)) ^ 32'h5A);
    endfunction

    // Behavioural single-port memory with 1-cycle read latency
    logic [7:0] mem_arr [32768];
    bit         mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32768; i++) mem_arr[i] = init_val(i);
            mem_init = 1'b1;
        end
        if (!mem_CEN) begin
            if (!mem_WEN) mem_arr[mem_A] = mem_D;
            else          mem_Q <= mem_arr[mem_A];
        end
    end

    // Reference model state
    logic [7:0] ref_mem [32768];
    logic       last_host_m;

    typedef struct {
        logic [14:0] base;
        logic [15:0] len;
        logic [14:0] stride;
        int          ready_mode;  // 0 always, 1 pattern 1,0,0, 2 random
        int          host_mode;   // 0 none, 1 continuous, 2 random
        bit          chk_first;
        int          exp_first;   // cycle of first out_valid after start, -1 never
        int          exp_done;    // cycle of done after start, 0 unchecked
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cen"},   32'(mem_CEN),   32'd1);
        chk({tag, "_wen"},   32'(mem_WEN),   32'd1);
        chk({tag, "_a"},     32'(mem_A),     32'd0);
        chk({tag, "_d"},     32'(mem_D),     32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"},  32'(out_data),  32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
    endtask

    // Entered and left at a falling edge
    task automatic host_write(input logic [14:0] a, input logic [7:0] d);
        host_wvalid = 1'b1;
        host_waddr  = a;
        host_wdata  = d;
        #1;
        chk("hw_ready", 32'(host_wready), 32'd1);
        chk("hw_cen",   32'(mem_CEN),     32'd0);
        chk("hw_wen",   32'(mem_WEN),     32'd0);
        chk("hw_addr",  32'(mem_A),       32'(a));
        chk("hw_data",  32'(mem_D),       32'(d));
        ref_mem[a]  = d;
        last_host_m = 1'b1;
        @(negedge clk);
        host_wvalid = 1'b0;
    endtask

    // Launch one stream and check every cycle until done has come and gone
    task automatic run_stream(input vec_t v);
        int          c;
        int          iss_q[$];
        logic [7:0]  exp_q[$];
        logic [14:0] ea;
        logic [14:0] ra;
        int          issued;
        int          hs;
        int          done_at;
        int          first_seen;
        int          done_seen;
        logic        exp_valid, pop_m, exp_sreq, exp_h, exp_s, exp_busy;

        ea = v.base;
        for (int i = 0; i < int'(v.len); i++) begin
            exp_q.push_back(ref_mem[ea]);
            ea = ea + v.stride;
        end
        ra         = v.base;
        issued     = 0;
        hs         = 0;
        first_seen = -1;
        done_seen  = -1;
        done_at    = (v.len == 16'd0) ? 2 : 1000000;
        start  = 1'b1;
        base   = v.base;
        len    = v.len;
        stride = v.stride;
        c = 0;
        while (c <= done_at + 1 && c < 400) begin
            if (c > 0) start = 1'b0;
            case (v.ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((c % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            case (v.host_mode)
                1:       host_wvalid = 1'b1;
                2:       host_wvalid = 1'($urandom_range(0, 1));
                default: host_wvalid = 1'b0;
            endcase
            host_waddr = 15'h5000 | 15'($urandom_range(0, 4095));
            host_wdata = 8'($urandom);
            #1;
            exp_valid = (iss_q.size() > 0) && (iss_q[0] <= c - 2);
            pop_m     = exp_valid && out_ready;
            exp_sreq  = (c >= 1) && (issued < int'(v.len)) && ((iss_q.size() - int'(pop_m)) < 2);
            exp_h     = host_wvalid && !(exp_sreq && last_host_m);
            exp_s     = exp_sreq && !exp_h;
            exp_busy  = (c >= 1) && (c <= done_at);
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) chk("out_data", 32'(out_data), 32'(exp_q[0]));
            chk("host_wready", 32'(host_wready), 32'(exp_h));
            chk("mem_CEN", 32'(mem_CEN), 32'(!(exp_h || exp_s)));
            chk("mem_WEN", 32'(mem_WEN), 32'(!exp_h));
            if (exp_s) chk("rd_addr", 32'(mem_A), 32'(ra));
            if (exp_h) begin
                chk("wr_addr", 32'(mem_A), 32'(host_waddr));
                chk("wr_data", 32'(mem_D), 32'(host_wdata));
            end
            chk("done", 32'(done), 32'(c == done_at));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (out_valid && first_seen < 0) first_seen = c;
            if (done && done_seen < 0) done_seen = c;
            if (pop_m) begin
                void'(iss_q.pop_front());
                void'(exp_q.pop_front());
                hs++;
                if (hs == int'(v.len)) done_at = c + 1;
            end
            if (exp_s) begin
                iss_q.push_back(c);
                issued++;
                ra = ra + v.stride;
            end
            if (exp_h) begin
                ref_mem[host_waddr] = host_wdata;
                last_host_m = 1'b1;
            end else if (exp_s) begin
                last_host_m = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        host_wvalid = 1'b0;
        out_ready   = 1'b0;
        start       = 1'b0;
        chk("stream_complete", 32'(hs), 32'(v.len));
        if (v.chk_first) chk("first_valid_lat", 32'(first_seen), 32'(v.exp_first));
        if (v.exp_done > 0) chk("done_lat", 32'(done_seen), 32'(v.exp_done));
    endtask

    vec_t vecs[5];
    vec_t rv;
    int   hs_cnt;

    initial begin
        // Directed table: expected first-valid and done cycles after start
        vecs[0] = '{15'h0000, 16'd8, 15'd1, 0, 0, 1'b1,  3, 11}; // basic
        vecs[1] = '{15'h7FFE, 16'd3, 15'd3, 0, 0, 1'b1,  3,  6}; // stride + wrap
        vecs[2] = '{15'h0000, 16'd6, 15'd1, 1, 0, 1'b1,  3,  0}; // backpressure
        vecs[3] = '{15'h0100, 16'd4, 15'd1, 0, 1, 1'b0,  0,  0}; // contention
        vecs[4] = '{15'h0000, 16'd0, 15'd1, 0, 0, 1'b1, -1,  2}; // zero length

        for (int i = 0; i < 32768; i++) ref_mem[i] = init_val(i);
        last_host_m = 1'b0;
        rst_n       = 1'b0;
        host_wvalid = 1'b0;
        host_waddr  = 15'd0;
        host_wdata  = 8'd0;
        start       = 1'b0;
        base        = 15'd0;
        len         = 16'd0;
        stride      = 15'd0;
        out_ready   = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) host_write(15'(i), 8'(8'h10 + i));
        host_write(15'h7FFE, 8'hA1);
        host_write(15'h0001, 8'hB2);
        host_write(15'h0004, 8'hC3);

        for (int i = 0; i < 5; i++) run_stream(vecs[i]);

        // Reset in the middle of a stream, after two elements were taken
        start     = 1'b1;
        base      = 15'h0000;
        len       = 16'd8;
        stride    = 15'd1;
        out_ready = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        hs_cnt = 0;
        for (int k = 0; k < 20 && hs_cnt < 2; k++) begin
            #1;
            if (out_valid && out_ready) hs_cnt++;
            @(negedge clk);
        end
        chk("rst_sync", 32'(hs_cnt), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        out_ready = 1'b0;
        rst_n     = 1'b1;
        last_host_m = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("post_rst_done",  32'(done),      32'd0);
            chk("post_rst_busy",  32'(busy),      32'd0);
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            chk("post_rst_cen",   32'(mem_CEN),   32'd1);
            @(negedge clk);
        end
        run_stream(vecs[0]);

        // Randomized streams against the reference model
        for (int n = 0; n < 25; n++) begin
            rv.base       = 15'($urandom_range(0, 16'h1FFF));
            rv.len        = 16'($urandom_range(0, 12));
            rv.stride     = 15'($urandom_range(0, 255));
            rv.ready_mode = $urandom_range(0, 2);
            rv.host_mode  = $urandom_range(0, 2);
            rv.chk_first  = 1'b0;
            rv.exp_first  = 0;
            rv.exp_done   = 0;
            run_stream(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
